// File: rtl/fixed_lpc_reconstructor.sv
// Fixed-order LPC reconstructor: rebuilds PCM samples from residuals using a
// order 0-4 polynomial predictor over the last four outputs, one sample per cycle.
module fixed_lpc_reconstructor #(
    parameter int SAMPLE_W   = 16,
    parameter int RESIDUAL_W = 20,
    parameter int ACC_W      = 24
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iFrameStart,
    input  logic [2:0]            iOrder,
    input  logic [15:0]           iBlockSize,
    input  logic                  iValid,
    input  logic [RESIDUAL_W-1:0] iResidual,
    output logic                  oReady,
    output logic                  oValid,
    output logic [SAMPLE_W-1:0]   oSample,
    input  logic                  iSampleReady,
    output logic                  oFrameDone,
    output logic                  oOverflow,
    output logic                  oError
);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_DECODE, S_DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]                  order_q;
    logic [15:0]                 bs_q;
    logic [15:0]                 cnt_q;
    logic [15:0]                 cnt_inc;
    logic signed [SAMPLE_W-1:0]  h1, h2, h3, h4;
    logic signed [SAMPLE_W-1:0]  sample_p1;
    logic                        vld_p1;
    logic                        frame_done;
    logic                        err;
    logic                        ovf;

    logic                        accept;
    logic                        drained;
    logic                        start_legal;
    logic                        start_bad;
    logic signed [ACC_W-1:0]     res_ext;
    logic signed [ACC_W-1:0]     pred;
    logic signed [ACC_W-1:0]     sum;
    logic signed [SAMPLE_W-1:0]  y;
    logic                        sum_ovf;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [SAMPLE_W-1:0] v);
        return {{(ACC_W-SAMPLE_W){v[SAMPLE_W-1]}}, v};
    endfunction

    // Binomial predictors built from shifts and adds only.
    function automatic logic signed [ACC_W-1:0] predict(
        input logic [2:0]                 ord,
        input logic signed [SAMPLE_W-1:0] p1,
        input logic signed [SAMPLE_W-1:0] p2,
        input logic signed [SAMPLE_W-1:0] p3,
        input logic signed [SAMPLE_W-1:0] p4
    );
        logic signed [ACC_W-1:0] a1, a2, a3, a4;
        a1 = sx(p1);
        a2 = sx(p2);
        a3 = sx(p3);
        a4 = sx(p4);
        case (ord)
            3'd1:    return a1;
            3'd2:    return (a1 <<< 1) - a2;
            3'd3:    return (a1 <<< 1) + a1 - (a2 <<< 1) - a2 + a3;
            3'd4:    return (a1 <<< 2) - (a2 <<< 2) - (a2 <<< 1) + (a3 <<< 2) - a4;
            default: return '0;
        endcase
    endfunction

    // A sum fits the sample range when all bits above the sample sign bit match it.
    function automatic logic fits_sample(input logic signed [ACC_W-1:0] s);
        return (&s[ACC_W-1:SAMPLE_W-1]) | ~(|s[ACC_W-1:SAMPLE_W-1]);
    endfunction

    assign cnt_inc     = cnt_q + 16'd1;
    assign drained     = ~vld_p1 | iSampleReady;
    assign oReady      = ((state == S_WARMUP) || (state == S_DECODE)) && drained;
    assign accept      = iValid & oReady;
    assign start_legal = (state == S_IDLE) && iFrameStart && (iOrder <= 3'd4) && (iBlockSize != 16'd0);
    assign start_bad   = (state == S_IDLE) && iFrameStart && ((iOrder > 3'd4) || (iBlockSize == 16'd0));
    assign res_ext     = $signed({{(ACC_W-RESIDUAL_W){iResidual[RESIDUAL_W-1]}}, iResidual});

    always_comb begin
        pred    = predict(order_q, h1, h2, h3, h4);
        sum     = res_ext + pred;
        y       = (state == S_WARMUP) ? $signed(iResidual[SAMPLE_W-1:0]) : sum[SAMPLE_W-1:0];
        sum_ovf = (state == S_DECODE) && !fits_sample(sum);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_legal) state_nxt = (iOrder == 3'd0) ? S_DECODE : S_WARMUP;
            S_WARMUP: if (accept) begin
                          if (cnt_inc == bs_q)                      state_nxt = S_DONE;
                          else if (cnt_inc == {13'd0, order_q})     state_nxt = S_DECODE;
                      end
            S_DECODE: if (accept && (cnt_inc == bs_q)) state_nxt = S_DONE;
            S_DONE:   if (drained) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == S_DONE) && drained;
            err        <= start_bad;
        end
    end

    // Stage p1: output register and history update on each accepted input.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            order_q   <= '0;
            bs_q      <= '0;
            cnt_q     <= '0;
            h1        <= '0;
            h2        <= '0;
            h3        <= '0;
            h4        <= '0;
            sample_p1 <= '0;
            vld_p1    <= 1'b0;
            ovf       <= 1'b0;
        end else if (start_legal) begin
            order_q <= iOrder;
            bs_q    <= iBlockSize;
            cnt_q   <= '0;
            h1      <= '0;
            h2      <= '0;
            h3      <= '0;
            h4      <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= cnt_inc;
            h4        <= h3;
            h3        <= h2;
            h2        <= h1;
            h1        <= y;
            sample_p1 <= y;
            vld_p1    <= 1'b1;
            if (sum_ovf) ovf <= 1'b1;
        end else if (iSampleReady) begin
            vld_p1 <= 1'b0;
        end
    end

    assign oValid     = vld_p1;
    assign oSample    = sample_p1;
    assign oFrameDone = frame_done;
    assign oOverflow  = ovf;
    assign oError     = err;

endmodule

// File: tb/tb_fixed_lpc_reconstructor.sv
// Self-checking bench for fixed_lpc_reconstructor: directed frames plus random
// streams produced by a reference LPC encoder, checked with immediate assertions.
module tb_fixed_lpc_reconstructor;

    localparam int SW = 16;
    localparam int RW = 20;

    logic          iClock = 1'b0;
    logic          iReset = 1'b1;
    logic          iFrameStart = 1'b0;
    logic [2:0]    iOrder = '0;
    logic [15:0]   iBlockSize = '0;
    logic          iValid = 1'b0;
    logic [RW-1:0] iResidual = '0;
    logic          iSampleReady = 1'b1;
    logic          oReady, oValid, oFrameDone, oOverflow, oError;
    logic [SW-1:0] oSample;

    fixed_lpc_reconstructor #(.SAMPLE_W(SW), .RESIDUAL_W(RW), .ACC_W(24)) dut (
        .iClock(iClock), .iReset(iReset), .iFrameStart(iFrameStart),
        .iOrder(iOrder), .iBlockSize(iBlockSize), .iValid(iValid),
        .iResidual(iResidual), .oReady(oReady), .oValid(oValid),
        .oSample(oSample), .iSampleReady(iSampleReady),
        .oFrameDone(oFrameDone), .oOverflow(oOverflow), .oError(oError)
    );

    always #5 iClock = ~iClock;

    int errors = 0;
    int checks = 0;
    int out_q[$];
    int in_q[$];
    int exp_q[$];
    int x_q[$];
    int fd_cnt = 0;
    bit rnd_bp = 0;

    // Collect every output handshake and frame-done pulse.
    always @(negedge iClock) begin
        if (!iReset && oValid && iSampleReady) out_q.push_back(int'($signed(oSample)));
        if (oFrameDone) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic start_frame(input int ord, input int bs);
        iOrder      = ord[2:0];
        iBlockSize  = bs[15:0];
        iFrameStart = 1'b1;
        tick();
        iFrameStart = 1'b0;
    endtask

    task automatic send_one(input int v);
        bit acc;
        acc       = 0;
        iValid    = 1'b1;
        iResidual = v[RW-1:0];
        for (int t = 0; t < 200 && !acc; t++) begin
            if (rnd_bp) iSampleReady = 1'($urandom_range(0, 1));
            @(negedge iClock);
            acc = oReady;
            tick();
        end
        iValid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic end_frame(input string tag, input int fd0, input int exp_ovf);
        iSampleReady = 1'b1;
        for (int t = 0; t < 50 && fd_cnt == fd0; t++) tick();
        tick();
        tick();
        chk({tag, "_framedone"}, fd_cnt - fd0, 1);
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_s%0d", tag, i), (i < out_q.size()) ? out_q[i] : -999999, exp_q[i]);
        chk({tag, "_ovf"}, int'(oOverflow), exp_ovf);
    endtask

    task automatic run_frame(input string tag, input int ord, input int exp_ovf);
        int fd0;
        out_q.delete();
        fd0 = fd_cnt;
        start_frame(ord, in_q.size());
        foreach (in_q[i]) send_one(in_q[i]);
        end_frame(tag, fd0, exp_ovf);
    endtask

    // Reference encoder: residual = x - polynomial extrapolation of the
    // previous `ord` samples; the first `ord` samples pass verbatim.
    function automatic void encode(input int ord);
        int c[5][4];
        int p;
        c = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, -1, 0, 0}, '{3, -3, 1, 0}, '{4, -6, 4, -1}};
        in_q.delete();
        for (int n = 0; n < x_q.size(); n++) begin
            if (n < ord) in_q.push_back(x_q[n]);
            else begin
                p = 0;
                for (int k = 1; k <= ord; k++) p += c[ord][k-1] * x_q[n-k];
                in_q.push_back(x_q[n] - p);
            end
        end
    endfunction

    task automatic chk_all_zero(input string tag);
        @(negedge iClock);
        chk({tag, "_ready"}, int'(oReady), 0);
        chk({tag, "_valid"}, int'(oValid), 0);
        chk({tag, "_sample"}, int'(oSample), 0);
        chk({tag, "_done"}, int'(oFrameDone), 0);
        chk({tag, "_ovf"}, int'(oOverflow), 0);
        chk({tag, "_err"}, int'(oError), 0);
    endtask

    initial begin
        int fd0;
        int ord;
        int bs;

        tick();
        tick();
        chk_all_zero("reset");
        tick();
        iReset = 1'b0;
        tick();

        in_q  = '{10, 20, 30, 40, 0, 0, 0, 0};
        exp_q = '{10, 20, 30, 40, 50, 60, 70, 80};
        run_frame("t1", 4, 0);

        in_q  = '{0, 1, 4, 9, 0, 0};
        exp_q = '{0, 1, 4, 9, 16, 25};
        run_frame("t2", 4, 0);

        // Stall the output while the frame is in flight.
        out_q.delete();
        fd0 = fd_cnt;
        iSampleReady = 1'b0;
        start_frame(2, 4);
        send_one(5);
        iValid    = 1'b1;
        iResidual = 20'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClock);
            chk($sformatf("t3_stall_ready%0d", i), int'(oReady), 0);
            chk($sformatf("t3_stall_valid%0d", i), int'(oValid), 1);
            chk($sformatf("t3_stall_sample%0d", i), int'($signed(oSample)), 5);
            tick();
        end
        iSampleReady = 1'b1;
        send_one(7);
        send_one(1);
        send_one(-1);
        exp_q = '{5, 7, 10, 12};
        end_frame("t3", fd0, 0);

        in_q  = '{32767, 1};
        exp_q = '{32767, -32768};
        run_frame("t4", 1, 1);

        start_frame(5, 4);
        @(negedge iClock);
        chk("t5_err_order", int'(oError), 1);
        chk("t5_err_order_ready", int'(oReady), 0);
        tick();
        @(negedge iClock);
        chk("t5_err_order_pulse", int'(oError), 0);
        chk("t5_err_order_ready2", int'(oReady), 0);
        tick();
        start_frame(2, 0);
        @(negedge iClock);
        chk("t5_err_bs", int'(oError), 1);
        chk("t5_err_bs_ready", int'(oReady), 0);
        tick();
        @(negedge iClock);
        chk("t5_err_bs_pulse", int'(oError), 0);
        tick();

        out_q.delete();
        fd0 = fd_cnt;
        start_frame(0, 3);
        @(negedge iClock);
        chk("t4_ovf_cleared", int'(oOverflow), 0);
        tick();
        send_one(3);
        send_one(-4);
        send_one(5);
        exp_q = '{3, -4, 5};
        end_frame("t5_o0", fd0, 0);

        // Reset in the middle of a frame.
        out_q.delete();
        fd0 = fd_cnt;
        start_frame(4, 8);
        send_one(10);
        send_one(20);
        send_one(30);
        iReset = 1'b1;
        tick();
        chk_all_zero("t6_reset");
        iReset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_no_done", fd_cnt - fd0, 0);
        in_q  = '{1, 2, 0, 0};
        exp_q = '{1, 2, 3, 4};
        run_frame("t6_next", 2, 0);

        // Random frames of every order, including frames shorter than the order.
        for (int f = 0; f < 10; f++) begin
            ord = f % 5;
            bs  = int'($urandom_range(1, 12));
            x_q.delete();
            for (int n = 0; n < bs; n++) x_q.push_back(int'($urandom_range(0, 16383)) - 8192);
            encode(ord);
            exp_q = x_q;
            run_frame($sformatf("rnd%0d_o%0d", f, ord), ord, 0);
        end

        // Long order-4 stream with random output backpressure.
        x_q.delete();
        for (int n = 0; n < 1000; n++) x_q.push_back(int'($urandom_range(0, 16383)) - 8192);
        encode(4);
        exp_q  = x_q;
        rnd_bp = 1;
        run_frame("long1000", 4, 0);
        rnd_bp = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
